regfile_writeback: RTL and testbench

//   Writer side of the 32x32 register file write port (D / A_D / write_enable).

---
 rtl/regfile_writeback_pkg.sv | 20 ++
 rtl/regfile_writeback_wb_match.sv | 37 +++
 rtl/regfile_writeback.sv | 128 ++++++++++++
 tb/tb_regfile_writeback.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register file writeback slice: width defaults,
// the hard-wired zero register index and a constant-foldable clog2.
package regfile_writeback_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned REG_ZERO       = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_writeback_wb_match.sv
// Youngest-match finder: scans queue entries oldest to youngest starting at
// rd_ptr so the last valid match (nearest wr_ptr) wins.
module wb_match
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = 4
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_rd,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data,
    input  logic [DEPTH-1:0]                 entry_valid,
    input  logic [clog2(DEPTH)-1:0]          rd_ptr,
    input  logic [ADDR_WIDTH-1:0]            addr,
    output logic                             hit,
    output logic [DATA_WIDTH-1:0]            data
);

    localparam int unsigned PW = clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = rd_ptr;
        for (int unsigned age = 0; age < DEPTH; age++) begin
            idx = rd_ptr + PW'(age);
            if (entry_valid[idx] && (entry_rd[idx] == addr) &&
                (addr != ADDR_WIDTH'(REG_ZERO))) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register file writer: in-order queue fed by LSU and ALU, drained at one
// write per cycle, with forwarding of queued values to two decode ports.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic [DATA_WIDTH-1:0] D,
    output logic [ADDR_WIDTH-1:0] A_D,
    output logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] fwd_addr0,
    input  logic [ADDR_WIDTH-1:0] fwd_addr1,
    output logic                  fwd_hit0,
    output logic                  fwd_hit1,
    output logic [DATA_WIDTH-1:0] fwd_data0,
    output logic [DATA_WIDTH-1:0] fwd_data1,
    output logic                  wb_empty
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] LSU_LIMIT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ALU_LIMIT = CW'(DEPTH - 2);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] q_rd;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] q_data;
    logic [DEPTH-1:0]                 q_valid;
    logic [PW-1:0]                    rd_ptr;
    logic [PW-1:0]                    wr_ptr;
    logic [PW-1:0]                    alu_slot;
    logic [PW-1:0]                    slot;
    logic [CW-1:0]                    count;
    logic                             lsu_push;
    logic                             alu_push;
    logic                             pop;

    // Ready looks only at the registered count, so a pop this cycle never
    // opens a slot early; ALU needs one more free slot since LSU goes first.
    assign lsu_ready = (count <= LSU_LIMIT);
    assign alu_ready = (count <= ALU_LIMIT);

    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != ADDR_WIDTH'(REG_ZERO));
    assign alu_push = alu_valid && alu_ready && (alu_rd != ADDR_WIDTH'(REG_ZERO));
    assign alu_slot = wr_ptr + PW'(lsu_push);

    assign pop          = (count != '0);
    assign write_enable = pop;
    assign wb_empty     = !pop;
    assign D            = pop ? q_data[rd_ptr] : '0;
    assign A_D          = pop ? q_rd[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (RES) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(lsu_push) + PW'(alu_push);
            count  <= count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RES) begin
            if (lsu_push) begin
                q_rd[wr_ptr]   <= lsu_rd;
                q_data[wr_ptr] <= lsu_data;
            end
            if (alu_push) begin
                q_rd[alu_slot]   <= alu_rd;
                q_data[alu_slot] <= alu_data;
            end
        end
    end

    always_comb begin
        q_valid = '0;
        slot    = rd_ptr;
        for (int unsigned age = 0; age < DEPTH; age++) begin
            slot = rd_ptr + PW'(age);
            if (CW'(age) < count) begin
                q_valid[slot] = 1'b1;
            end
        end
    end

    wb_match #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_match0 (
        .entry_rd   (q_rd),
        .entry_data (q_data),
        .entry_valid(q_valid),
        .rd_ptr     (rd_ptr),
        .addr       (fwd_addr0),
        .hit        (fwd_hit0),
        .data       (fwd_data0)
    );

    wb_match #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_match1 (
        .entry_rd   (q_rd),
        .entry_data (q_data),
        .entry_valid(q_valid),
        .rd_ptr     (rd_ptr),
        .addr       (fwd_addr1),
        .hit        (fwd_hit1),
        .data       (fwd_data1)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: accepted results queue up as expected
// commits, and a negedge monitor pops them whenever write_enable is presented.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    logic          CLK = 1'b0;
    logic          RES = 1'b1;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic [DW-1:0] D;
    logic [AW-1:0] A_D;
    logic          write_enable;
    logic [AW-1:0] fwd_addr0 = '0;
    logic [AW-1:0] fwd_addr1 = '0;
    logic          fwd_hit0;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data0;
    logic [DW-1:0] fwd_data1;
    logic          wb_empty;

    regfile_writeback #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RES         (RES),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .D           (D),
        .A_D         (A_D),
        .write_enable(write_enable),
        .fwd_addr0   (fwd_addr0),
        .fwd_addr1   (fwd_addr1),
        .fwd_hit0    (fwd_hit0),
        .fwd_hit1    (fwd_hit1),
        .fwd_data0   (fwd_data0),
        .fwd_data1   (fwd_data1),
        .wb_empty    (wb_empty)
    );

    always #5 CLK = ~CLK;

    entry_t sb[$];
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending entry for an address; {hit, data}.
    function automatic logic [DW:0] fwd_model(input logic [AW-1:0] a);
        if (a == '0) return '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].rd == a) return {1'b1, sb[i].data};
        end
        return '0;
    endfunction

    task automatic clear_inputs();
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        fwd_addr0 = '0;   fwd_addr1 = '0;
    endtask

    // Called 1 time unit after a posedge; returns 1 time unit after the next.
    task automatic step(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input logic [AW-1:0] f0, input logic [AW-1:0] f1);
        int unsigned n;
        logic        lacc;
        logic        aacc;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        fwd_addr0 = f0; fwd_addr1 = f1;
        #1;
        n    = sb.size();
        lacc = lv && (n <= DEPTH - 1);
        aacc = av && (n <= DEPTH - 2);
        check("lsu_ready", 64'(lsu_ready), 64'(n <= DEPTH - 1));
        check("alu_ready", 64'(alu_ready), 64'(n <= DEPTH - 2));
        check("wb_empty", 64'(wb_empty), 64'(n == 0));
        check("fwd0", 64'({fwd_hit0, fwd_data0}), 64'(fwd_model(f0)));
        check("fwd1", 64'({fwd_hit1, fwd_data1}), 64'(fwd_model(f1)));
        @(posedge CLK);
        if (lacc && lrd != '0) sb.push_back('{rd: lrd, data: ld});
        if (aacc && ard != '0) sb.push_back('{rd: ard, data: ad});
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        end
    endtask

    // Valid traffic during the reset cycle must be ignored.
    task automatic do_reset();
        RES = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD_0007;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hDEAD_0009;
        @(posedge CLK);
        sb.delete();
        #1;
        RES = 1'b0;
        clear_inputs();
    endtask

    initial begin : monitor
        entry_t exp_e;
        forever begin
            @(negedge CLK);
            if (!RES) begin
                if (write_enable) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", 64'({A_D, D}), 64'(0));
                        check("spurious_we", 64'(write_enable), 64'(0));
                    end else begin
                        exp_e = sb.pop_front();
                        check("commit", 64'({A_D, D}), 64'(exp_e));
                    end
                end else begin
                    check("missing_write", 64'(sb.size()), 64'(0));
                    check("idle_head", 64'({A_D, D}), 64'(0));
                end
            end
        end
    end

    initial begin : stimulus
        logic [AW-1:0] r0, r1, f0, f1;
        logic          v0, v1;

        @(posedge CLK);
        do_reset();
        idle(2);

        // Single LSU result reaches the write port next cycle, then drains.
        step(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, '0, '0, 5'd5, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd5, '0);
        idle(2);

        // Same-cycle LSU/ALU to one register: LSU older, ALU value forwarded.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd3);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd4);
        idle(2);

        // Back-to-back dual traffic exercises the ready limits.
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1, AW'(i + 1), 32'h1000 + i, 1'b1, AW'(i + 10), 32'h2000 + i,
                 AW'(i), AW'(i + 9));
        end
        idle(5);

        // rd == 0 completes the handshake but never enqueues.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, '0, 5'd0);
        step(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, '0, 5'd0);
        idle(2);

        // Mid-operation reset with three entries queued.
        step(1'b1, 5'd20, 32'hC0, 1'b1, 5'd21, 32'hC1, '0, '0);
        step(1'b1, 5'd22, 32'hC2, 1'b1, 5'd23, 32'hC3, 5'd22, 5'd23);
        do_reset();
        idle(3);

        // Mixed traffic with a narrow address range for frequent hits.
        for (int unsigned i = 0; i < 400; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            r0 = AW'($urandom_range(0, 7));
            r1 = AW'($urandom_range(0, 7));
            f0 = AW'($urandom_range(0, 7));
            f1 = AW'($urandom_range(0, 7));
            step(v0, r0, $urandom, v1, r1, $urandom, f0, f1);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
